imem_arbiter: RTL

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: two-port (fetch, loader) arbiter onto a single
// request/ack instruction memory port with a bounded ack wait.
//
// Ports
//   clk, rst_n            : rising-edge clock, synchronous active-low reset
//   f_req/f_addr          : fetch read request (hold until f_gnt)
//   f_gnt/f_rvalid/f_err  : fetch grant, read-done and timeout pulses
//   f_rdata               : last fetch read data (held between reads)
//   l_req/l_we/l_addr/
//   l_wdata               : loader read/write request (hold until l_gnt)
//   l_gnt/l_rvalid/l_err  : loader grant, done and timeout pulses
//   l_rdata               : last loader read data (held across writes)
//   mem_req/mem_we/
//   mem_addr/mem_wdata    : registered memory command, stable until ack
//   mem_rdata/mem_ack     : memory read data and completion
//   busy                  : a transaction is outstanding
//
// Build option: define IMEM_ARB_RR_EN for round-robin on ties;
// otherwise the loader always beats fetch.

module imem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  output logic              f_err,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              l_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy
);

  localparam logic [7:0] TO_CNT = 8'(TIMEOUT);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic              owner_q;
  logic              owner_d;
  logic [7:0]        wait_q;
  logic [7:0]        wait_d;

  logic              f_gnt_d;
  logic              f_rvalid_d;
  logic              f_err_d;
  logic [DATA_W-1:0] f_rdata_d;
  logic              l_gnt_d;
  logic              l_rvalid_d;
  logic              l_err_d;
  logic [DATA_W-1:0] l_rdata_d;
  logic              mem_req_d;
  logic              mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              busy_d;

  logic              grant;
  logic              pick_l;
  logic              ack_done;
  logic              to_done;

  assign grant = (state_q == IDLE) && (f_req || l_req);

`ifdef IMEM_ARB_RR_EN
  // 1 = loader owned the last grant; reset value lets fetch win
  // the first tie.
  logic last_q;

  assign pick_l = l_req && (!f_req || !last_q);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (grant) begin
      last_q <= pick_l;
    end
  end
`else
  assign pick_l = l_req;
`endif

  // Ack has priority over a timeout landing on the same edge.
  assign ack_done = (state_q == BUSY) && mem_ack;
  assign to_done  = (state_q == BUSY) && !mem_ack
                    && (wait_q == TO_CNT);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wait_d      = wait_q;
    f_gnt_d     = 1'b0;
    f_rvalid_d  = 1'b0;
    f_err_d     = 1'b0;
    f_rdata_d   = f_rdata;
    l_gnt_d     = 1'b0;
    l_rvalid_d  = 1'b0;
    l_err_d     = 1'b0;
    l_rdata_d   = l_rdata;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    busy_d      = busy;

    unique case (state_q)
      IDLE: begin
        if (grant) begin
          state_d   = BUSY;
          owner_d   = pick_l;
          wait_d    = '0;
          mem_req_d = 1'b1;
          busy_d    = 1'b1;
          if (pick_l) begin
            l_gnt_d     = 1'b1;
            mem_we_d    = l_we;
            mem_addr_d  = l_addr;
            mem_wdata_d = l_wdata;
          end else begin
            f_gnt_d     = 1'b1;
            mem_we_d    = 1'b0;
            mem_addr_d  = f_addr;
            mem_wdata_d = '0;
          end
        end
      end
      BUSY: begin
        unique case (1'b1)
          ack_done: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            busy_d    = 1'b0;
            if (owner_q) begin
              l_rvalid_d = 1'b1;
              if (!mem_we) begin
                l_rdata_d = mem_rdata;
              end
            end else begin
              f_rvalid_d = 1'b1;
              f_rdata_d  = mem_rdata;
            end
          end
          to_done: begin
            state_d   = IDLE;
            mem_req_d = 1'b0;
            busy_d    = 1'b0;
            if (owner_q) begin
              l_err_d = 1'b1;
            end else begin
              f_err_d = 1'b1;
            end
          end
          default: begin
            wait_d = wait_q + 8'd1;
          end
        endcase
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      wait_q    <= '0;
      f_gnt     <= 1'b0;
      f_rvalid  <= 1'b0;
      f_err     <= 1'b0;
      f_rdata   <= '0;
      l_gnt     <= 1'b0;
      l_rvalid  <= 1'b0;
      l_err     <= 1'b0;
      l_rdata   <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      wait_q    <= wait_d;
      f_gnt     <= f_gnt_d;
      f_rvalid  <= f_rvalid_d;
      f_err     <= f_err_d;
      f_rdata   <= f_rdata_d;
      l_gnt     <= l_gnt_d;
      l_rvalid  <= l_rvalid_d;
      l_err     <= l_err_d;
      l_rdata   <= l_rdata_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      busy      <= busy_d;
    end
  end

endmodule
